fp_align_unit: RTL and testbench
================================

FP_ALIGN_UNIT -- requirements
Module: fp_align_unit

Interface
REQ-001 The block SHALL use clock clk and reset reset, where reset is synchronous and active-high.
REQ-002 Port clk  in  1  rising-edge clock.
REQ-003 Port reset  in  1  synchronous active-high reset.
REQ-004 Port in_valid  in  1  operand pair present.
REQ-005 Port in_ready  out  1  block can accept an operand pair.
REQ-006 Port in_A  in  32  IEEE-754 single operand A.
REQ-007 Port in_B  in  32  IEEE-754 single operand B.
REQ-008 Port out_valid  out  1  aligned result present.
REQ-009 Port out_ready  in  1  downstream adder/subtractor accepts the result.
REQ-010 Port out_sa, out_sb  out  1 each  sign of the larger-exponent operand / of the shifted operand.
REQ-011 Port out_exp  out  8  common (larger effective) exponent.
REQ-012 Port out_ma  out  24  larger-exponent mantissa with explicit hidden bit.
REQ-013 Port out_mb  out  24  smaller-exponent mantissa after right shift.
REQ-014 Port out_guard, out_sticky  out  1 each  first bit shifted out / OR of all later bits shifted out.
REQ-015 Port out_swapped  out  1  B had the strictly larger effective exponent.
REQ-016 Port out_special  out  1  at least one operand has exponent 0xFF; no alignment is performed.

Function
REQ-017 Handshake: transfer on in_valid&&in_ready; in_ready=1 only in IDLE; out_valid=1 only in DONE; out fields SHALL be stable while out_valid&&!out_ready.
REQ-018 FSM states: IDLE, CMP, SHIFT, DONE.
REQ-019 Transitions: IDLE -> CMP on input transfer (operands registered). CMP -> DONE if special, diff=0, or diff>=26. CMP -> SHIFT if 1<=diff<=25. SHIFT -> DONE when the shift counter reaches 0. DONE -> IDLE on out_ready.
REQ-020 Operand decode: for exp=0 (zero or subnormal), hidden bit=0 and effective exponent=1; for exp 1..254, hidden bit=1 and effective exponent=exp.
REQ-021 CMP: diff=|EA-EB| over effective exponents; if EB>EA then swap operands and set out_swapped=1; for equal exponents out_swapped=0.
REQ-022 SHIFT: one bit per cycle — mb>>=1, guard<=old mb[0], sticky<=sticky|old guard; counter (5-bit) loaded with diff and decremented each cycle.
REQ-023 diff>=26 in CMP: out_mb=0, out_guard=0, out_sticky=|mb, with no SHIFT cycles.
REQ-024 Special: out_exp=max(raw EA,EB), mantissas carry the hidden bit per REQ-020, no shift, out_guard=out_sticky=0, out_special=1; all other cases out_special=0.
REQ-025 Latency from the accepting edge to out_valid: 2 cycles for diff=0, diff>=26, or special; 2+diff cycles for diff 1..25.
REQ-026 out_ready asserted while not in DONE SHALL be ignored; in_valid while not in IDLE SHALL be ignored.
REQ-027 Back-to-back: DONE->IDLE costs one cycle, so the minimum initiation interval is 3 cycles.

Reset
REQ-028 When reset=1 at a clock edge, in any state including mid-SHIFT, the FSM SHALL go to IDLE; all out_* ports, the counter, and the operand registers SHALL be cleared to 0; in_ready SHALL be 1 from the following cycle.
REQ-029 An in-flight operation SHALL be discarded on reset with no out_valid pulse.

Verification
REQ-030 Scenario: A=0x3F800000, B=0x3F800000 -> 2 cycles; exp=0x7F, ma=mb=0x800000, guard=sticky=0, swapped=0.
REQ-031 Scenario: A=0x3F800000, B=0x40400000 -> 3 cycles; swapped=1, exp=0x80, ma=0xC00000, mb=0x400000, guard=0.
REQ-032 Scenario: A=0x4B800000, B=0x3F800000 (diff 24) -> 26 cycles; mb=0, guard=1, sticky=0.
REQ-033 Scenario: A=0x4C000000, B=0x3F000001 (diff 26) -> 2 cycles; mb=0, guard=0, sticky=1.
REQ-034 Scenario: A=0x7F800000, B=0x3F800000 -> 2 cycles; special=1, exp=0xFF, no shift.
REQ-035 Scenario: out_ready held low for 5 cycles in DONE -> outputs stable, in_ready=0; then reset pulsed mid-SHIFT -> IDLE, all outputs 0, no out_valid.

Source files
------------

// File: rtl/fp_align_unit.sv
// Exponent-compare and mantissa-align stage for a single-precision adder/subtractor.
// Right-shifts the smaller-exponent mantissa one bit per cycle while tracking guard and sticky bits.
module fp_align_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_A,
  input  logic [31:0] in_B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_sa,
  output logic        out_sb,
  output logic [7:0]  out_exp,
  output logic [23:0] out_ma,
  output logic [23:0] out_mb,
  output logic        out_guard,
  output logic        out_sticky,
  output logic        out_swapped,
  output logic        out_special
);

  // state | meaning
  // IDLE  | waiting for an operand pair
  // CMP   | compare effective exponents, pick larger operand
  // SHIFT | shift smaller mantissa right one bit per cycle
  // DONE  | aligned result held until downstream accepts
  typedef enum logic [1:0] {IDLE, CMP, SHIFT, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] ra, rb;
  logic [4:0]  cnt;

  logic [7:0]  ea, eb, diff, exp_raw_max;
  logic [23:0] mant_a, mant_b, mant_big, mant_small;
  logic        b_big, special;

  // Subnormals and zero use effective exponent 1 with no hidden bit.
  always_comb begin
    ea          = (ra[30:23] == 8'd0) ? 8'd1 : ra[30:23];
    eb          = (rb[30:23] == 8'd0) ? 8'd1 : rb[30:23];
    mant_a      = {|ra[30:23], ra[22:0]};
    mant_b      = {|rb[30:23], rb[22:0]};
    special     = (&ra[30:23]) | (&rb[30:23]);
    b_big       = eb > ea;
    diff        = b_big ? (eb - ea) : (ea - eb);
    mant_big    = b_big ? mant_b : mant_a;
    mant_small  = b_big ? mant_a : mant_b;
    exp_raw_max = (rb[30:23] > ra[30:23]) ? rb[30:23] : ra[30:23];
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid) state_nxt = CMP;
      CMP:     if (special || diff == 8'd0 || diff >= 8'd26) state_nxt = DONE;
               else state_nxt = SHIFT;
      SHIFT:   if (cnt <= 5'd1) state_nxt = DONE;
      DONE:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      ra          <= '0;
      rb          <= '0;
      cnt         <= '0;
      out_sa      <= 1'b0;
      out_sb      <= 1'b0;
      out_exp     <= '0;
      out_ma      <= '0;
      out_mb      <= '0;
      out_guard   <= 1'b0;
      out_sticky  <= 1'b0;
      out_swapped <= 1'b0;
      out_special <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: if (in_valid) begin
          ra <= in_A;
          rb <= in_B;
        end
        CMP: begin
          out_guard <= 1'b0;
          if (special) begin
            out_sa      <= ra[31];
            out_sb      <= rb[31];
            out_exp     <= exp_raw_max;
            out_ma      <= mant_a;
            out_mb      <= mant_b;
            out_sticky  <= 1'b0;
            out_swapped <= 1'b0;
            out_special <= 1'b1;
          end else begin
            out_sa      <= b_big ? rb[31] : ra[31];
            out_sb      <= b_big ? ra[31] : rb[31];
            out_exp     <= b_big ? eb : ea;
            out_ma      <= mant_big;
            out_swapped <= b_big;
            out_special <= 1'b0;
            cnt         <= diff[4:0];
            if (diff >= 8'd26) begin
              out_mb     <= '0;
              out_sticky <= |mant_small;
            end else begin
              out_mb     <= mant_small;
              out_sticky <= 1'b0;
            end
          end
        end
        SHIFT: begin
          out_mb     <= out_mb >> 1;
          out_guard  <= out_mb[0];
          out_sticky <= out_sticky | out_guard;
          cnt        <= cnt - 5'd1;
        end
        default: ;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

endmodule

// File: tb/tb_fp_align_unit.sv
// Directed bench for fp_align_unit: hand-computed alignment vectors, stall, and mid-shift reset.
module tb_fp_align_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_A = '0;
  logic [31:0] in_B = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic        out_sa, out_sb;
  logic [7:0]  out_exp;
  logic [23:0] out_ma, out_mb;
  logic        out_guard, out_sticky, out_swapped, out_special;

  int n_checks = 0;
  int n_pass   = 0;
  int lat;
  logic seen;

  fp_align_unit dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_A(in_A), .in_B(in_B),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sa(out_sa), .out_sb(out_sb), .out_exp(out_exp),
    .out_ma(out_ma), .out_mb(out_mb),
    .out_guard(out_guard), .out_sticky(out_sticky),
    .out_swapped(out_swapped), .out_special(out_special)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Launch one operand pair and measure cycles from the accepting edge to out_valid.
  task automatic launch(input logic [31:0] a, input logic [31:0] b, output int cycles);
    int k;
    k = 0;
    while (!in_ready && k < 50) begin tick(); k++; end
    in_A = a; in_B = b; in_valid = 1'b1;
    cycles = 0;
    do begin
      tick();
      in_valid = 1'b0;
      cycles++;
    end while (!out_valid && cycles < 40);
  endtask

  task automatic run_op(input string name, input logic [31:0] a, input logic [31:0] b,
                        input int e_lat, input logic [7:0] e_exp, input logic [23:0] e_ma,
                        input logic [23:0] e_mb, input logic e_g, input logic e_s,
                        input logic e_sw, input logic e_sp);
    int c;
    launch(a, b, c);
    chk({name, ".latency"}, c, e_lat);
    chk({name, ".exp"},     out_exp, e_exp);
    chk({name, ".ma"},      out_ma, e_ma);
    chk({name, ".mb"},      out_mb, e_mb);
    chk({name, ".guard"},   out_guard, e_g);
    chk({name, ".sticky"},  out_sticky, e_s);
    chk({name, ".swapped"}, out_swapped, e_sw);
    chk({name, ".special"}, out_special, e_sp);
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("release.in_ready", in_ready, 1'b1);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk("rst.in_ready",  in_ready, 1'b1);
    chk("rst.out_valid", out_valid, 1'b0);
    chk("rst.out_exp",   out_exp, 8'h00);
    chk("rst.out_mb",    out_mb, 24'h0);

    run_op("eq",     32'h3F800000, 32'h3F800000, 2,  8'h7F, 24'h800000, 24'h800000, 0, 0, 0, 0);
    chk("eq.sign_a", out_sa, 1'b0);
    release_out();
    run_op("swap1",  32'h3F800000, 32'h40400000, 3,  8'h80, 24'hC00000, 24'h400000, 0, 0, 1, 0);
    release_out();
    run_op("d24",    32'h4B800000, 32'h3F800000, 26, 8'h97, 24'h800000, 24'h000000, 1, 0, 0, 0);
    release_out();
    run_op("d25",    32'h4B800000, 32'h3F000000, 27, 8'h97, 24'h800000, 24'h000000, 0, 1, 0, 0);
    release_out();
    run_op("d26",    32'h4C000000, 32'h3F000001, 2,  8'h98, 24'h800000, 24'h000000, 0, 1, 0, 0);
    release_out();
    run_op("inf",    32'h7F800000, 32'h3F800000, 2,  8'hFF, 24'h800000, 24'h800000, 0, 0, 0, 1);
    release_out();
    run_op("subn",   32'h00000001, 32'h00800000, 2,  8'h01, 24'h000001, 24'h800000, 0, 0, 0, 0);
    release_out();
    run_op("signs",  32'h3F800000, 32'hC0000000, 3,  8'h80, 24'h800000, 24'h400000, 0, 0, 1, 0);
    chk("signs.sa", out_sa, 1'b1);
    chk("signs.sb", out_sb, 1'b0);
    release_out();

    // Stall in DONE with a competing input that must be ignored.
    run_op("stall", 32'h3F800000, 32'h3F800000, 2, 8'h7F, 24'h800000, 24'h800000, 0, 0, 0, 0);
    in_A = 32'h4B800000; in_B = 32'h3F800000; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("stall.out_valid", out_valid, 1'b1);
      chk("stall.in_ready",  in_ready, 1'b0);
      chk("stall.exp",       out_exp, 8'h7F);
      chk("stall.mb",        out_mb, 24'h800000);
    end
    in_valid = 1'b0;
    release_out();

    // Reset in the middle of a long shift.
    in_A = 32'h4B800000; in_B = 32'h3F800000; in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (6) tick();
    chk("midrst.in_shift", out_valid, 1'b0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    out_ready = 1'b0;
    chk("midrst.in_ready",  in_ready, 1'b1);
    chk("midrst.out_valid", out_valid, 1'b0);
    chk("midrst.exp",       out_exp, 8'h00);
    chk("midrst.ma",        out_ma, 24'h0);
    chk("midrst.mb",        out_mb, 24'h0);
    chk("midrst.flags",     {out_sa, out_sb, out_guard, out_sticky, out_swapped, out_special}, 6'b0);
    seen = 1'b0;
    repeat (30) begin
      tick();
      if (out_valid) seen = 1'b1;
    end
    chk("midrst.no_valid", seen, 1'b0);

    run_op("post", 32'h3F800000, 32'h40400000, 3, 8'h80, 24'hC00000, 24'h400000, 0, 0, 1, 0);
    release_out();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
